radio_to_deep_fifo: RTL and testbench

RADIO_TO_DEEP_FIFO -- requirements
Module: radio_to_deep_fifo

---
 rtl/radio_to_deep_fifo.sv | 164 ++++++++++++++++
 tb/tb_radio_to_deep_fifo.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/radio_to_deep_fifo.sv
// Radio RX CHDR stream into a packet buffer that only releases whole, length-checked packets.
// Optional macro RADIO2FIFO_SID_CHECK_EN additionally rejects headers whose masked SID differs from R0_DATA_SID.
module radio_to_deep_fifo #(
  parameter logic [31:0] R0_DATA_SID    = 32'h50,
  parameter logic [31:0] DEMUX_SID_MASK = 32'hffff_fff0,
  parameter int          MAX_PKT_BYTES  = 1472,
  parameter int          BUF_AW         = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] rx_tdata,
  input  logic        rx_tlast,
  input  logic        rx_tvalid,
  output logic        rx_tready,
  output logic [63:0] c2h_fifo_pre_tdata,
  output logic        c2h_fifo_pre_tlast,
  output logic        c2h_fifo_pre_tvalid,
  input  logic        c2h_fifo_pre_tready,
  output logic [15:0] drop_count,
  output logic        pkt_avail,
  output logic [1:0]  dbg_wr_state
);
  // Handshake: a beat moves on a port only in a cycle where tvalid and tready are both high at the rising edge.
  localparam logic [1:0] W_HEAD = 2'd0;
  localparam logic [1:0] W_BODY = 2'd1;
  localparam logic [1:0] W_DROP = 2'd2;
  localparam logic [15:0] MAX_LEN = 16'(MAX_PKT_BYTES);
  localparam logic [BUF_AW:0] DEPTH = {1'b1, {BUF_AW{1'b0}}};

  logic [64:0]     mem_q [DEPTH];
  logic [1:0]      state_q, state_d;
  logic [BUF_AW:0] wr_ptr_q, wr_ptr_d, commit_ptr_q, commit_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [BUF_AW:0] pkt_cnt_q, pkt_cnt_d, free_ent;
  logic [13:0]     beat_cnt_q, beat_cnt_d, qw_q, qw_d, hdr_qw, beat_n, cur_qw;
  logic [15:0]     drop_q, drop_d, hdr_len;
  logic            pkt_avail_q, pkt_avail_d;
  logic            out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [63:0]     out_data_q, out_data_d;
  logic            hdr_legal, sid_ok, take_beat, mem_we, pkt_inc, pkt_dec, drop_inc, rd_load;

  assign hdr_len  = rx_tdata[47:32];
  assign hdr_qw   = {1'b0, hdr_len[15:3]} + 14'(|hdr_len[2:0]);
`ifdef RADIO2FIFO_SID_CHECK_EN
  assign sid_ok   = ((rx_tdata[31:0] & DEMUX_SID_MASK) == R0_DATA_SID);
`else
  assign sid_ok   = 1'b1;
`endif
  assign hdr_legal = ({rx_tdata[63:62], rx_tdata[60]} inside {3'b000, 3'b001}) &&
                     (hdr_len >= 16'd8) && (hdr_len <= MAX_LEN) && sid_ok;
  // rd_ptr advances when an entry moves into the output register, so space frees per beat.
  assign free_ent = DEPTH - (wr_ptr_q - rd_ptr_q);
  assign beat_n   = (state_q == W_HEAD) ? 14'd1 : beat_cnt_q + 14'd1;
  assign cur_qw   = (state_q == W_HEAD) ? hdr_qw : qw_q;

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    beat_cnt_d   = beat_cnt_q;
    qw_d         = qw_q;
    take_beat    = 1'b0;
    mem_we       = 1'b0;
    pkt_inc      = 1'b0;
    drop_inc     = 1'b0;
    if (rx_tvalid) begin
      case (state_q)
        W_HEAD: begin
          if (hdr_legal && (32'(hdr_qw) <= 32'(free_ent))) begin
            qw_d      = hdr_qw;
            take_beat = 1'b1;
          end else begin
            drop_inc = 1'b1;
            state_d  = rx_tlast ? W_HEAD : W_DROP;
          end
        end
        W_BODY:  take_beat = 1'b1;
        W_DROP:  if (rx_tlast) state_d = W_HEAD;
        default: state_d = W_HEAD;
      endcase
      if (take_beat) begin
        if (beat_n == cur_qw && rx_tlast) begin
          mem_we       = 1'b1;
          wr_ptr_d     = wr_ptr_q + 1'b1;
          commit_ptr_d = wr_ptr_q + 1'b1;
          pkt_inc      = 1'b1;
          state_d      = W_HEAD;
        end else if (beat_n == cur_qw || rx_tlast) begin
          // Length mismatch: forget the partial packet by rewinding to the last commit.
          wr_ptr_d = commit_ptr_q;
          drop_inc = 1'b1;
          state_d  = rx_tlast ? W_HEAD : W_DROP;
        end else begin
          mem_we     = 1'b1;
          wr_ptr_d   = wr_ptr_q + 1'b1;
          beat_cnt_d = beat_n;
          state_d    = W_BODY;
        end
      end
    end
  end

  always_comb begin
    rd_load     = (rd_ptr_q != commit_ptr_q) && (!out_valid_q || c2h_fifo_pre_tready);
    rd_ptr_d    = rd_ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    if (rd_load) begin
      rd_ptr_d    = rd_ptr_q + 1'b1;
      out_valid_d = 1'b1;
      {out_last_d, out_data_d} = mem_q[rd_ptr_q[BUF_AW-1:0]];
    end else if (c2h_fifo_pre_tready) begin
      out_valid_d = 1'b0;
    end
    pkt_dec   = out_valid_q && c2h_fifo_pre_tready && out_last_q;
    pkt_cnt_d = pkt_cnt_q;
    if (pkt_inc && !pkt_dec) pkt_cnt_d = pkt_cnt_q + 1'b1;
    else if (pkt_dec && !pkt_inc) pkt_cnt_d = pkt_cnt_q - 1'b1;
    pkt_avail_d = (pkt_cnt_d != '0);
    drop_d      = (drop_inc && drop_q != 16'hffff) ? drop_q + 16'd1 : drop_q;
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_ptr_q[BUF_AW-1:0]] <= {(beat_n == cur_qw), rx_tdata};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= W_HEAD;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      pkt_cnt_q    <= '0;
      beat_cnt_q   <= '0;
      qw_q         <= '0;
      drop_q       <= '0;
      pkt_avail_q  <= 1'b0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      pkt_cnt_q    <= pkt_cnt_d;
      beat_cnt_q   <= beat_cnt_d;
      qw_q         <= qw_d;
      drop_q       <= drop_d;
      pkt_avail_q  <= pkt_avail_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      out_data_q   <= out_data_d;
    end
  end

  assign rx_tready           = ~rst;
  assign c2h_fifo_pre_tdata  = out_data_q;
  assign c2h_fifo_pre_tlast  = out_last_q;
  assign c2h_fifo_pre_tvalid = out_valid_q;
  assign drop_count          = drop_q;
  assign pkt_avail           = pkt_avail_q;
  assign dbg_wr_state        = state_q;
endmodule

// File: tb/tb_radio_to_deep_fifo.sv
// Directed bench for radio_to_deep_fifo: whole-packet pass/drop, rollback, backpressure and reset discard.
module tb_radio_to_deep_fifo;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] rx_tdata = '0;
  logic        rx_tlast = 1'b0, rx_tvalid = 1'b0, rx_tready;
  logic [63:0] c2h_tdata;
  logic        c2h_tlast, c2h_tvalid;
  logic        c2h_tready = 1'b1;
  logic [15:0] drop_count;
  logic        pkt_avail;
  logic [1:0]  dbg_wr_state;

  logic [64:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int beats_seen = 0;
  int exp_drop = 0;

  radio_to_deep_fifo dut (
    .clk(clk), .rst(rst),
    .rx_tdata(rx_tdata), .rx_tlast(rx_tlast), .rx_tvalid(rx_tvalid), .rx_tready(rx_tready),
    .c2h_fifo_pre_tdata(c2h_tdata), .c2h_fifo_pre_tlast(c2h_tlast),
    .c2h_fifo_pre_tvalid(c2h_tvalid), .c2h_fifo_pre_tready(c2h_tready),
    .drop_count(drop_count), .pkt_avail(pkt_avail), .dbg_wr_state(dbg_wr_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard and output-stability monitor; inputs change only just after posedge.
  logic        prev_valid = 1'b0, prev_ready = 1'b0, prev_rst = 1'b1, prev_last = 1'b0;
  logic [63:0] prev_data = '0;
  always @(negedge clk) begin
    logic [64:0] exp;
    if (!rst && !prev_rst && prev_valid && !prev_ready) begin
      n_checks++;
      if (c2h_tvalid !== 1'b1 || c2h_tdata !== prev_data || c2h_tlast !== prev_last) begin
        n_fail++;
        $display("FAIL axi_stable: got v=%0b d=%h l=%0b required v=1 d=%h l=%0b",
                 c2h_tvalid, c2h_tdata, c2h_tlast, prev_data, prev_last);
      end
    end
    if (!rst && c2h_tvalid && c2h_tready) begin
      beats_seen++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_beat: got d=%h l=%0b required no beat", c2h_tdata, c2h_tlast);
      end else begin
        exp = exp_q.pop_front();
        if ({c2h_tlast, c2h_tdata} !== exp) begin
          n_fail++;
          $display("FAIL out_beat: got %h required %h", {c2h_tlast, c2h_tdata}, exp);
        end
      end
    end
    prev_valid = c2h_tvalid; prev_ready = c2h_tready; prev_rst = rst;
    prev_data  = c2h_tdata;  prev_last  = c2h_tlast;
  end

  // Drivers
  task automatic send_beat(input logic [63:0] d, input logic l);
    rx_tdata = d; rx_tlast = l; rx_tvalid = 1'b1;
    @(posedge clk); #1;
    rx_tvalid = 1'b0; rx_tlast = 1'b0;
  endtask

  function automatic logic [63:0] beat_data(input logic [15:0] len, input logic [31:0] sid,
                                            input logic [7:0] tag, input int i);
    if (i == 1) return {8'h00, tag, len, sid};
    return {tag, 24'h0, 32'(i)};
  endfunction

  task automatic send_pkt(input logic [15:0] len, input logic [31:0] sid, input int nbeats,
                          input int tlast_at, input logic push, input logic [7:0] tag);
    for (int i = 1; i <= nbeats; i++) begin
      if (push) exp_q.push_back({(i == nbeats), beat_data(len, sid, tag, i)});
      send_beat(beat_data(len, sid, tag, i), (i == tlast_at));
    end
  endtask

  task automatic wait_drain(input int budget, input string name);
    int c = 0;
    while (exp_q.size() != 0 && c < budget) begin
      @(posedge clk); c++;
    end
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: got %0d beats outstanding required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_drop(input string name);
    @(negedge clk);
    n_checks++;
    if (drop_count !== 16'(exp_drop)) begin
      n_fail++;
      $display("FAIL %s_drop: got %0d required %0d", name, drop_count, exp_drop);
    end
    @(posedge clk); #1;
  endtask

  // Scenarios
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (rx_tready !== 1'b0) begin n_fail++; $display("FAIL rst_rx_tready: got %0b required 0", rx_tready); end
    n_checks++;
    if (c2h_tvalid !== 1'b0 || c2h_tlast !== 1'b0) begin
      n_fail++; $display("FAIL rst_c2h: got v=%0b l=%0b required 0 0", c2h_tvalid, c2h_tlast);
    end
    n_checks++;
    if (pkt_avail !== 1'b0) begin n_fail++; $display("FAIL rst_pkt_avail: got %0b required 0", pkt_avail); end
    n_checks++;
    if (drop_count !== 16'd0) begin n_fail++; $display("FAIL rst_drop: got %0d required 0", drop_count); end
    n_checks++;
    if (dbg_wr_state !== 2'd0) begin n_fail++; $display("FAIL rst_state: got %0d required 0", dbg_wr_state); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (rx_tready !== 1'b1) begin n_fail++; $display("FAIL run_rx_tready: got %0b required 1", rx_tready); end
    @(posedge clk); #1;
  endtask

  task automatic test_max_pkt();
    send_pkt(16'd1472, 32'h50, 184, 184, 1'b1, 8'h11);
    wait_drain(400, "max_pkt");
    check_drop("max_pkt");
  endtask

  task automatic test_oversize();
    send_pkt(16'd1480, 32'h50, 185, 185, 1'b0, 8'h22);
    exp_drop++;
    check_drop("oversize");
    send_pkt(16'd16, 32'h50, 2, 2, 1'b1, 8'h23);
    wait_drain(20, "oversize_next");
  endtask

  task automatic test_early_tlast();
    send_pkt(16'd64, 32'h50, 5, 5, 1'b0, 8'h33);
    exp_drop++;
    check_drop("early_tlast");
    send_pkt(16'd16, 32'h50, 2, 2, 1'b1, 8'h34);
    wait_drain(20, "early_tlast_next");
  endtask

  task automatic test_back_to_back();
    int start;
    c2h_tready = 1'b0;
    send_pkt(16'd1472, 32'h50, 184, 184, 1'b1, 8'h41);
    send_pkt(16'd1472, 32'h50, 184, 184, 1'b1, 8'h42);
    send_pkt(16'd1472, 32'h50, 184, 184, 1'b0, 8'h43);
    exp_drop++;
    check_drop("full");
    n_checks++;
    if (pkt_avail !== 1'b1) begin n_fail++; $display("FAIL full_pkt_avail: got %0b required 1", pkt_avail); end
    start = beats_seen;
    c2h_tready = 1'b1;
    repeat (368) @(posedge clk);
    #1;
    n_checks++;
    if (beats_seen - start != 368) begin
      n_fail++; $display("FAIL b2b_rate: got %0d beats required 368", beats_seen - start);
    end
    wait_drain(20, "b2b");
    n_checks++;
    if (pkt_avail !== 1'b0) begin n_fail++; $display("FAIL b2b_pkt_avail: got %0b required 0", pkt_avail); end
  endtask

  task automatic test_sid();
`ifdef RADIO2FIFO_SID_CHECK_EN
    send_pkt(16'd16, 32'h60, 2, 2, 1'b0, 8'h51);
    exp_drop++;
`else
    send_pkt(16'd16, 32'h60, 2, 2, 1'b1, 8'h51);
`endif
    wait_drain(20, "sid");
    check_drop("sid");
  endtask

  task automatic test_latency();
    logic found = 1'b0;
    send_pkt(16'd8, 32'h50, 1, 1, 1'b1, 8'h61);
    for (int k = 0; k < 3 && !found; k++) begin
      @(negedge clk);
      if (c2h_tvalid) found = 1'b1;
    end
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL latency: got no valid within 3 cycles required valid"); end
    wait_drain(10, "latency");
  endtask

  task automatic test_mid_reset();
    c2h_tready = 1'b0;
    send_pkt(16'd16, 32'h50, 2, 2, 1'b0, 8'h71);
    send_beat(beat_data(16'd80, 32'h50, 8'h72, 1), 1'b0);
    send_beat(beat_data(16'd80, 32'h50, 8'h72, 2), 1'b0);
    rx_tdata = beat_data(16'd80, 32'h50, 8'h72, 3); rx_tvalid = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    rx_tvalid = 1'b0;
    exp_drop = 0;
    @(negedge clk);
    n_checks++;
    if (c2h_tvalid !== 1'b0 || c2h_tlast !== 1'b0) begin
      n_fail++; $display("FAIL midrst_c2h: got v=%0b l=%0b required 0 0", c2h_tvalid, c2h_tlast);
    end
    n_checks++;
    if (pkt_avail !== 1'b0 || drop_count !== 16'd0) begin
      n_fail++; $display("FAIL midrst_status: got avail=%0b drop=%0d required 0 0", pkt_avail, drop_count);
    end
    n_checks++;
    if (rx_tready !== 1'b0) begin n_fail++; $display("FAIL midrst_rx_tready: got %0b required 0", rx_tready); end
    @(posedge clk); #1;
    rst = 1'b0;
    c2h_tready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    send_pkt(16'd24, 32'h50, 3, 3, 1'b1, 8'h73);
    wait_drain(20, "midrst_next");
    check_drop("midrst");
  endtask

  initial begin
    test_reset();
    test_max_pkt();
    test_oversize();
    test_early_tlast();
    test_back_to_back();
    test_sid();
    test_latency();
    test_mid_reset();
    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
